fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// Parametrised fetch stage with an instruction prefetch queue between the PC and Decode.
// It fetches sequentially from instruction memory and buffers {PC, instr, ExcCode} entries in a DEPTH-deep FIFO.
// Decode pulls entries through a valid/ready handshake.
// Redirects flush the queue and reload the PC. Priority: eret > interrupt > branch/jump.
// PARAMETERS
// DEPTH      4            queue entries, power of two, >=2
// RESET_PC   32'h3000     PC after reset
// EXC_VEC    32'h4180     interrupt/exception entry PC
// IM_LO      32'h3000     lowest legal fetch address
// IM_HI      32'h4ffc     highest legal fetch address
// PORTS
// clk         in   1   clock, rising edge
// reset       in   1   asynchronous, active-low reset
// im_addr     out  32  fetch address to IM; always equals the PC register
// im_rdata    in   32  instruction from IM, combinational on im_addr
// eret        in   1   return from exception; redirect to epc
// epc         in   32  return target
// int_req     in   1   interrupt/exception request; redirect to EXC_VEC
// br_redir    in   1   branch/jump redirect from Decode
// br_target   in   32  branch/jump target
// out_valid   out  1   queue head is valid
// out_ready   in   1   Decode accepts the head this cycle
// out_pc      out  32  PC of the head entry
// out_instr   out  32  instruction of the head entry (0 when out_exc != 0)
// out_exc     out  5   ExcCode of the head entry (0, or 4 = AdEL on fetch)
// count       out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
// - Reset (reset=0, async): pc=RESET_PC; rd/wr pointers=0; count=0; halt=0.
//   Outputs out_valid=0, out_pc=0, out_instr=0, out_exc=0.
// - Redirect: redir = eret|int_req|br_redir. Target selection: eret ? epc : int_req ? EXC_VEC : br_target.
// - Redirect cycle: the queue is flushed (count=0, pointers=0), pc<=target, halt<=0.
//   No push and no pop take effect that cycle, even if out_ready=1.
// - Fetch exception: exc = (pc[1:0]!=0) || pc<IM_LO || pc>IM_HI. A faulting entry is stored with instr=0 and exc=5'd4.
// - Push (no redirect): taken when count<DEPTH and halt=0.
//   The entry {pc, exc?0:im_rdata, exc?4:0} is written at wr_ptr; pc<=pc+4 (mod 2^32).
//   If exc, halt<=1. Fetch stops until the next redirect and the PC holds.
// - Full: when count==DEPTH, no push. pc holds, even if a pop happens in the same cycle; there is no bypass.
// - Pop (no redirect): taken when out_valid&&out_ready. rd_ptr advances.
// - Simultaneous push+pop: count is unchanged. Pointers wrap modulo DEPTH.
// - Head output: out_valid = (count!=0). out_pc/out_instr/out_exc read combinationally from queue[rd_ptr].
//   When count==0 these outputs are 0.
// - Latency: an entry pushed at edge N is visible on the outputs after edge N. From reset release, out_valid rises after the first clk edge.
// - out_ready while out_valid=0 is ignored.
// - Reset asserted mid-operation clears everything immediately, regardless of clk.
// TESTING
// 1. Release reset, out_ready=0, IM returns 32'h1000_0000+addr.
//    -> 4 edges later count=4, head pc=32'h3000; im_addr holds 32'h3010 while full.
// 2. Keep out_ready=1 continuously.
//    -> one entry per cycle with out_pc 3000,3004,3008,...; count stays 1.
// 3. br_redir=1, br_target=32'h3100 while count=3 and out_ready=1.
//    -> next cycle count=0, no pop counted; the following cycle head pc=32'h3100.
// 4. eret=1 (epc=32'h3200) and int_req=1 in the same cycle.
//    -> pc=32'h3200 (eret wins); the queue is flushed.
// 5. Redirect to 32'h3002, then to 32'h5000.
//    -> each time exactly one entry with out_exc=4 and out_instr=0, then fetch halts (count stays 1) until int_req.
//    int_req then gives pc=32'h4180.
// 6. Assert reset low mid-burst, between clock edges.
//    -> out_valid=0 and count=0 immediately; after release, fetch restarts at 32'h3000.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-deep prefetch queue of {pc, instr, exc} entries.
// Fetches sequentially, halts on a fetch fault, and flushes and reloads on a redirect.
module fetch_queue_entry #(
  parameter int W = 69
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h3000,
  parameter logic [31:0] EXC_VEC  = 32'h4180,
  parameter logic [31:0] IM_LO    = 32'h3000,
  parameter logic [31:0] IM_HI    = 32'h4ffc,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [31:0]   im_addr,
  input  logic [31:0]   im_rdata,
  input  logic          eret,
  input  logic [31:0]   epc,
  input  logic          int_req,
  input  logic          br_redir,
  input  logic [31:0]   br_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [4:0]    out_exc,
  output logic [CW-1:0] count
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } entry_t;
  localparam int EW = $bits(entry_t);

  logic [31:0]   pc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          halt;
  logic          redir, exc, push, pop;
  logic [31:0]   target;
  entry_t        wr_ent, head;
  logic [DEPTH-1:0][EW-1:0] ent_q;

  assign im_addr = pc;
  assign redir   = eret | int_req | br_redir;
  assign target  = eret ? epc : (int_req ? EXC_VEC : br_target);
  assign exc     = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

  // Redirect wins over both queue ports; full blocks push even if a pop frees a slot.
  assign push = !redir && (count < CW'(DEPTH)) && !halt;
  assign pop  = !redir && out_valid && out_ready;

  assign wr_ent = '{pc: pc, instr: exc ? 32'd0 : im_rdata, exc: exc ? 5'd4 : 5'd0};

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      fetch_queue_entry #(.W(EW)) u_ent (
        .clk   (clk),
        .reset (reset),
        .we    (push && (wr_ptr == AW'(i))),
        .d     (wr_ent),
        .q     (ent_q[i])
      );
    end
  endgenerate

  assign head      = ent_q[rd_ptr];
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc    : 32'd0;
  assign out_instr = out_valid ? head.instr : 32'd0;
  assign out_exc   = out_valid ? head.exc   : 5'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      halt   <= 1'b0;
    end else if (redir) begin
      pc     <= target;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      halt   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        pc     <= pc + 32'd4;
        if (exc) halt <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: queue-level reference model feeds a scoreboard
// that a negedge monitor drains on every Decode handshake.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] EXC_VEC = 32'h4180;
  localparam logic [31:0] IM_LO   = 32'h3000;
  localparam logic [31:0] IM_HI   = 32'h4ffc;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   im_addr, im_rdata;
  logic          eret, int_req, br_redir, out_ready;
  logic [31:0]   epc, br_target;
  logic          out_valid;
  logic [31:0]   out_pc, out_instr;
  logic [4:0]    out_exc;
  logic [CW-1:0] count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_pc;
  logic        m_halt;
  int          m_cnt;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  assign im_rdata = 32'h1000_0000 + im_addr;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .im_addr(im_addr), .im_rdata(im_rdata),
    .eret(eret), .epc(epc), .int_req(int_req), .br_redir(br_redir),
    .br_target(br_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= IM_LO) && (a <= IM_HI);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc   = 32'h3000;
    m_halt = 1'b0;
    m_cnt  = 0;
  endtask

  // Applies the rules for one clock edge using the inputs held across it.
  task automatic model_step();
    ent_t e;
    int   pushed, popped;
    if (eret || int_req || br_redir) begin
      exp_q.delete();
      m_cnt  = 0;
      m_halt = 1'b0;
      m_pc   = eret ? epc : (int_req ? EXC_VEC : br_target);
    end else begin
      popped = (m_cnt > 0 && out_ready) ? 1 : 0;
      pushed = (m_cnt < DEPTH && !m_halt) ? 1 : 0;
      if (pushed == 1) begin
        e.pc    = m_pc;
        e.instr = legal(m_pc) ? 32'h1000_0000 + m_pc : 32'd0;
        e.exc   = legal(m_pc) ? 5'd0 : 5'd4;
        exp_q.push_back(e);
        if (!legal(m_pc)) m_halt = 1'b1;
        m_pc = m_pc + 32'd4;
      end
      m_cnt = m_cnt + pushed - popped;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    eret = 0; int_req = 0; br_redir = 0; out_ready = 0;
    epc = 32'h0; br_target = 32'h0;
  endtask

  // Monitor: head/occupancy against the scoreboard, pop on each accepted handshake.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("im_addr", im_addr, m_pc);
      if (exp_q.size() != 0) begin
        chk("head_pc", out_pc, exp_q[0].pc);
        chk("head_instr", out_instr, exp_q[0].instr);
        chk("head_exc", 32'(out_exc), 32'(exp_q[0].exc));
        if (out_valid && out_ready && !(eret || int_req || br_redir))
          void'(exp_q.pop_front());
      end else begin
        chk("empty_pc", out_pc, 32'd0);
        chk("empty_instr", out_instr, 32'd0);
      end
    end
  end

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 7))
      0: return 32'h3002;
      1: return 32'h5000;
      2: return 32'h4ffc;
      3: return 32'h2ffc;
      4: return 32'h3000;
      default: return 32'h3000 + ($urandom_range(0, 2047) << 2);
    endcase
  endfunction

  task automatic mid_reset();
    #2 reset = 0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_im_addr", im_addr, 32'h3000);
    model_reset();
    idle();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1;
  endtask

  initial begin
    int r;
    idle();
    model_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_pc", out_pc, 32'd0);
    chk("reset_instr", out_instr, 32'd0);
    chk("reset_exc", 32'(out_exc), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    reset = 1;

    // Fill with Decode stalled
    repeat (4) step();
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_head", out_pc, 32'h3000);
    repeat (2) step();
    chk("full_im_addr", im_addr, 32'h3010);

    // Flush and stream with out_ready held
    br_redir = 1; br_target = 32'h3000; out_ready = 1;
    step();
    br_redir = 0;
    repeat (6) step();
    chk("stream_count", 32'(count), 32'd1);

    // Redirect with count=3 and out_ready=1
    br_redir = 1; br_target = 32'h3040; out_ready = 0;
    step();
    br_redir = 0;
    repeat (3) step();
    chk("pre_br_count", 32'(count), 32'd3);
    br_redir = 1; br_target = 32'h3100; out_ready = 1;
    step();
    br_redir = 0; out_ready = 0;
    chk("br_flush_count", 32'(count), 32'd0);
    step();
    chk("br_head", out_pc, 32'h3100);

    // eret beats int_req
    eret = 1; epc = 32'h3200; int_req = 1;
    step();
    eret = 0; int_req = 0;
    chk("eret_pc", im_addr, 32'h3200);
    chk("eret_flush", 32'(count), 32'd0);

    // Misaligned then out-of-range targets halt fetch after one faulting entry
    br_redir = 1; br_target = 32'h3002;
    step();
    br_redir = 0;
    repeat (4) step();
    chk("mis_count", 32'(count), 32'd1);
    chk("mis_exc", 32'(out_exc), 32'd4);
    chk("mis_instr", out_instr, 32'd0);
    br_redir = 1; br_target = 32'h5000;
    step();
    br_redir = 0;
    repeat (4) step();
    chk("hi_count", 32'(count), 32'd1);
    chk("hi_exc", 32'(out_exc), 32'd4);
    int_req = 1;
    step();
    int_req = 0;
    chk("int_pc", im_addr, 32'h4180);

    // Reset in the middle of a burst
    out_ready = 1;
    repeat (3) step();
    mid_reset();
    step();
    chk("restart_head", out_pc, 32'h3000);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      idle();
      out_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 3) begin eret = 1; epc = pick_target(); end
      if (r >= 2 && r < 6) int_req = 1;
      if (r >= 5 && r < 12) begin br_redir = 1; br_target = pick_target(); end
      step();
      if (c == 1000) mid_reset();
    end

    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
